// File: rtl/alu_pkg.sv
// Shared constants for the ALU console: function codes, button indices,
// LED flag positions and the operand-tracking state type.
package alu_pkg;

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_NOT = 3'b010;
  localparam logic [2:0] FN_AND = 3'b011;
  localparam logic [2:0] FN_OR  = 3'b100;
  localparam logic [2:0] FN_XOR = 3'b101;
  localparam logic [2:0] FN_SLT = 3'b110;
  localparam logic [2:0] FN_EQ  = 3'b111;

  localparam int BTN_LOADA = 0;
  localparam int BTN_LOADB = 1;
  localparam int BTN_EXEC  = 2;
  localparam int BTN_ACC   = 3;
  localparam int BTN_CLEAR = 4;

  localparam int LED_ERR   = 12;
  localparam int LED_ZERO  = 13;
  localparam int LED_OVF   = 14;
  localparam int LED_CARRY = 15;

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_HAS_A,
    ST_HAS_B,
    ST_READY,
    ST_SHOW
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU. One shared adder serves add, subtract and the
// signed less-than compare.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       func,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             ovf,
  output logic             carry
);

  logic             sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic             lt;

  always_comb begin
    sub     = (func != FN_ADD);
    b_op    = sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    add_ovf = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    // Sign of A-B corrected by overflow gives the true signed ordering.
    lt      = sum[WIDTH-1] ^ add_ovf;

    out   = '0;
    ovf   = 1'b0;
    carry = 1'b0;
    case (func)
      FN_ADD, FN_SUB: begin
        out   = sum[WIDTH-1:0];
        ovf   = add_ovf;
        carry = sum[WIDTH];
      end
      FN_NOT:  out = ~a;
      FN_AND:  out = a & b;
      FN_OR:   out = a | b;
      FN_XOR:  out = a ^ b;
      FN_SLT:  out[0] = lt;
      FN_EQ:   out[0] = (a == b);
      default: out = '0;
    endcase
    zero = (out == '0);
  end

endmodule

// File: rtl/alu_console.sv
// Board ALU console: debounced buttons latch operands and run the ALU; the
// registered result and flags drive the LEDs and hex digits.
module alu_console
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NSEG      = 2,
  parameter int DB_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        btn,
  input  logic [15:0]       sw,
  output logic [4*NSEG-1:0] seg,
  output logic [15:0]       ledr
);

  localparam int CW  = $clog2(DB_CYCLES + 1);
  localparam int EXT = (4 * NSEG > WIDTH) ? 4 * NSEG : WIDTH;

  logic [1:0] vld_q, vld_d;
  logic [4:0] evt;

  // Marks when the sync chain holds real samples again after reset.
  always_comb vld_d = {vld_q[0], 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_db
      logic          s1_q, s1_d, s2_q, s2_d;
      logic          db_q, db_d, prev_q, prev_d, armed_q, armed_d;
      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        s1_d   = btn[gi];
        s2_d   = s1_q;
        prev_d = db_q;
        db_d   = db_q;
        cnt_d  = '0;
        if (s2_q != db_q) begin
          if (cnt_q == CW'(DB_CYCLES - 1)) db_d = s2_q;
          else                             cnt_d = cnt_q + 1'b1;
        end
        // A button held through reset stays disarmed until seen released.
        armed_d = armed_q | (vld_q[1] & ~s2_q);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_q    <= 1'b0;
          s2_q    <= 1'b0;
          db_q    <= 1'b0;
          prev_q  <= 1'b0;
          armed_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          s1_q    <= s1_d;
          s2_q    <= s2_d;
          db_q    <= db_d;
          prev_q  <= prev_d;
          armed_q <= armed_d;
          cnt_q   <= cnt_d;
        end
      end

      assign evt[gi] = db_q & ~prev_q & armed_q;
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, carry_q, carry_d, err_q, err_d;
  logic             acc_sel;
  logic [WIDTH-1:0] core_a, core_out;
  logic             core_zero, core_ovf, core_carry;

  assign acc_sel = evt[BTN_ACC] & ~evt[BTN_CLEAR] & ~evt[BTN_LOADA] &
                   ~evt[BTN_LOADB] & ~evt[BTN_EXEC];
  assign core_a  = acc_sel ? res_q : a_q;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a     (core_a),
    .b     (b_q),
    .func  (sw[15:13]),
    .out   (core_out),
    .zero  (core_zero),
    .ovf   (core_ovf),
    .carry (core_carry)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    carry_d = carry_q;
    err_d   = err_q;
    if (evt[BTN_CLEAR]) begin
      state_d = ST_EMPTY;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      zero_d  = 1'b0;
      ovf_d   = 1'b0;
      carry_d = 1'b0;
      err_d   = 1'b0;
    end else if (evt[BTN_LOADA]) begin
      a_d = sw[WIDTH-1:0];
      case (state_q)
        ST_EMPTY: state_d = ST_HAS_A;
        ST_HAS_B: state_d = ST_READY;
        default:  state_d = state_q;
      endcase
    end else if (evt[BTN_LOADB]) begin
      b_d = sw[WIDTH-1:0];
      case (state_q)
        ST_EMPTY: state_d = ST_HAS_B;
        ST_HAS_A: state_d = ST_READY;
        default:  state_d = state_q;
      endcase
    end else if (evt[BTN_EXEC] || acc_sel) begin
      if ((state_q == ST_SHOW) || (evt[BTN_EXEC] && state_q == ST_READY)) begin
        if (acc_sel) a_d = res_q;
        res_d   = core_out;
        zero_d  = core_zero;
        ovf_d   = core_ovf;
        carry_d = core_carry;
        err_d   = 1'b0;
        state_d = ST_SHOW;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  logic [EXT-1:0] res_ext;
  logic           unused_sw;

  assign unused_sw = ^sw[12:WIDTH];

  always_comb begin
    res_ext              = '0;
    res_ext[WIDTH-1:0]   = res_q;
    seg                  = res_ext[4*NSEG-1:0];
    ledr                 = '0;
    ledr[WIDTH-1:0]      = res_q;
    ledr[LED_ERR]        = err_q;
    ledr[LED_ZERO]       = zero_q;
    ledr[LED_OVF]        = ovf_q;
    ledr[LED_CARRY]      = carry_q;
  end

endmodule

// File: tb/tb_alu_console.sv
// Bench for alu_console: fixed vector table, hand-built timing/corner sequences,
// and random button traffic checked against an arithmetic model.
module tb_alu_console;

  localparam int WIDTH = 8;
  localparam int NSEG  = 2;
  localparam int DB    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  btn;
  logic [15:0] sw;
  logic [7:0]  seg;
  logic [15:0] ledr;

  int n_vec  = 0;
  int n_fail = 0;

  int ma, mb, mres;
  bit av, bv, shown, merr, mz, mo, mc;

  alu_console #(.WIDTH(WIDTH), .NSEG(NSEG), .DB_CYCLES(DB)) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .sw   (sw),
    .seg  (seg),
    .ledr (ledr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] swv;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[32];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int idx, input logic [15:0] swv);
    @(negedge clk);
    sw       = swv;
    btn[idx] = 1'b1;
    tick(DB + 5);
    btn[idx] = 1'b0;
    tick(DB + 5);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn = '0;
    tick(2);
    rst = 1'b0;
    tick(4);
    ma = 0; mb = 0; mres = 0;
    av = 0; bv = 0; shown = 0; merr = 0; mz = 0; mo = 0; mc = 0;
  endtask

  function automatic void ref_alu(input int a, input int b, input int f,
                                  output int r, output bit z, output bit o, output bit c);
    int sa, sb, s;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    o = 0;
    c = 0;
    case (f)
      0: begin s = a + b; r = s % 256; c = (s > 255); o = (sa + sb > 127) || (sa + sb < -128); end
      1: begin s = a + (255 - b) + 1; r = s % 256; c = (s > 255); o = (sa - sb > 127) || (sa - sb < -128); end
      2: r = 255 - a;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (sa < sb) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
    z = (r == 0);
  endfunction

  task automatic model_event(input int idx, input logic [15:0] swv);
    int f;
    int r;
    bit z, o, c;
    f = int'(swv[15:13]);
    case (idx)
      4: begin
        ma = 0; mb = 0; mres = 0;
        av = 0; bv = 0; shown = 0; merr = 0; mz = 0; mo = 0; mc = 0;
      end
      0: begin ma = int'(swv[7:0]); av = 1; end
      1: begin mb = int'(swv[7:0]); bv = 1; end
      2: begin
        if (av && bv) begin
          ref_alu(ma, mb, f, r, z, o, c);
          mres = r; mz = z; mo = o; mc = c; merr = 0; shown = 1;
        end else merr = 1;
      end
      default: begin
        if (shown) begin
          ref_alu(mres, mb, f, r, z, o, c);
          ma = mres; mres = r; mz = z; mo = o; mc = c; merr = 0;
        end else merr = 1;
      end
    endcase
  endtask

  function automatic logic [15:0] exp_ledr();
    logic [15:0] e;
    e      = '0;
    e[7:0] = mres[7:0];
    e[12]  = merr;
    e[13]  = mz;
    e[14]  = mo;
    e[15]  = mc;
    return e;
  endfunction

  initial begin
    logic [15:0] e;
    logic [15:0] rsw;
    int          ridx, roll;

    rst = 1'b1;
    btn = '0;
    sw  = '0;
    tbl[0]  = '{0, 16'h0007, 16'h0000};
    tbl[1]  = '{1, 16'h0005, 16'h0000};
    tbl[2]  = '{2, 16'h0000, 16'h000C};
    tbl[3]  = '{0, 16'h007F, 16'h000C};
    tbl[4]  = '{1, 16'h0001, 16'h000C};
    tbl[5]  = '{2, 16'h0000, 16'h4080};
    tbl[6]  = '{0, 16'h00FF, 16'h4080};
    tbl[7]  = '{2, 16'h0000, 16'hA000};
    tbl[8]  = '{0, 16'h0080, 16'hA000};
    tbl[9]  = '{2, 16'hC000, 16'h0001};
    tbl[10] = '{4, 16'h0000, 16'h0000};
    tbl[11] = '{2, 16'h0000, 16'h1000};
    tbl[12] = '{0, 16'h0001, 16'h1000};
    tbl[13] = '{1, 16'h0002, 16'h1000};
    tbl[14] = '{2, 16'h0000, 16'h0003};
    tbl[15] = '{3, 16'h0000, 16'h0005};
    tbl[16] = '{3, 16'h0000, 16'h0007};
    tbl[17] = '{3, 16'h0000, 16'h0009};
    tbl[18] = '{4, 16'h0000, 16'h0000};
    tbl[19] = '{0, 16'h0011, 16'h0000};
    tbl[20] = '{3, 16'h0000, 16'h1000};
    tbl[21] = '{1, 16'h0022, 16'h1000};
    tbl[22] = '{2, 16'h2000, 16'h00EF};
    tbl[23] = '{2, 16'h4000, 16'h00EE};
    tbl[24] = '{2, 16'h6000, 16'h2000};
    tbl[25] = '{2, 16'h8000, 16'h0033};
    tbl[26] = '{2, 16'hA000, 16'h0033};
    tbl[27] = '{2, 16'hE000, 16'h2000};
    tbl[28] = '{1, 16'h0011, 16'h2000};
    tbl[29] = '{2, 16'hE000, 16'h0001};
    tbl[30] = '{2, 16'h2000, 16'hA000};
    tbl[31] = '{2, 16'hC000, 16'h2000};

    #1;
    chk("reset_ledr", ledr, 16'h0000);
    chk("reset_seg", {8'h00, seg}, 16'h0000);
    do_reset();

    // Press-to-LED latency on exec.
    press(0, 16'h0007);
    press(1, 16'h0005);
    sw     = 16'h0000;
    btn[2] = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("latency_early", ledr, 16'h0000);
    @(posedge clk);
    #1 chk("latency_ledr", ledr, 16'h000C);
    chk("latency_seg", {8'h00, seg}, 16'h000C);
    @(negedge clk);
    btn[2] = 1'b0;
    tick(10);
    $display("latency sequence ledr=%h seg=%h", ledr, seg);

    do_reset();
    for (int i = 0; i < 32; i++) begin
      press(tbl[i].idx, tbl[i].swv);
      e = tbl[i].exp;
      $display("table %0d btn=%0d sw=%h ledr=%h seg=%h", i, tbl[i].idx, tbl[i].swv, ledr, seg);
      chk("table_ledr", ledr, e);
      chk("table_seg", {8'h00, seg}, {8'h00, e[7:0]});
    end

    // Bouncing loadA must not load; then a held press loads once.
    do_reset();
    press(0, 16'h0001);
    press(1, 16'h0002);
    press(2, 16'h0000);
    @(negedge clk);
    sw = 16'h0055;
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      tick(2);
    end
    btn[0] = 1'b0;
    tick(DB + 5);
    press(2, 16'h0000);
    $display("bounce loadA then exec ledr=%h", ledr);
    chk("bounce_noload", ledr, 16'h0003);
    press(0, 16'h000A);
    press(2, 16'h0000);
    chk("bounce_held_load", ledr, 16'h000C);

    // Bouncing acc followed by a hold gives exactly one accumulate.
    @(negedge clk);
    sw = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      btn[3] = ~btn[3];
      tick(2);
    end
    btn[3] = 1'b1;
    tick(DB + 5);
    btn[3] = 1'b0;
    tick(DB + 5);
    $display("bounce acc ledr=%h", ledr);
    chk("bounce_acc_once", ledr, 16'h000E);

    // Clear and exec accepted together: clear wins.
    @(negedge clk);
    btn = 5'b10100;
    tick(DB + 5);
    btn = '0;
    tick(DB + 5);
    $display("clear+exec ledr=%h", ledr);
    chk("clear_wins", ledr, 16'h0000);
    press(2, 16'h0000);
    chk("clear_state_empty", ledr, 16'h1000);

    // Reset mid-debounce with exec held.
    press(0, 16'h0004);
    press(1, 16'h0004);
    press(2, 16'h0000);
    chk("pre_rst_result", ledr, 16'h0008);
    @(negedge clk);
    btn[2] = 1'b1;
    tick(3);
    #2 rst = 1'b1;
    #1 chk("async_rst_ledr", ledr, 16'h0000);
    chk("async_rst_seg", {8'h00, seg}, 16'h0000);
    tick(2);
    rst = 1'b0;
    tick(20);
    $display("held through reset ledr=%h", ledr);
    chk("held_no_event", ledr, 16'h0000);
    btn[2] = 1'b0;
    tick(DB + 5);
    press(2, 16'h0000);
    chk("repress_event", ledr, 16'h1000);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 120; i++) begin
      roll = $urandom_range(0, 99);
      if (roll < 4)       ridx = 4;
      else if (roll < 26) ridx = 0;
      else if (roll < 48) ridx = 1;
      else if (roll < 78) ridx = 2;
      else                ridx = 3;
      rsw = 16'($urandom);
      press(ridx, rsw);
      model_event(ridx, rsw);
      e = exp_ledr();
      $display("random %0d btn=%0d sw=%h ledr=%h expect=%h", i, ridx, rsw, ledr, e);
      chk("random_ledr", ledr, e);
      chk("random_seg", {8'h00, seg}, {8'h00, e[7:0]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
